// File: rtl/xram_arbiter_if.sv
// XRAM bus bundle: one instance per master port and one for the XRAM side.
// A master drives addr/data_out/stb/wr and receives ack/data_in; the slave
// side (the arbiter for m0..m2, the XRAM model for the shared port) does the
// reverse.
interface xram_arbiter_if;
  logic [15:0] addr;
  logic [7:0]  data_out;
  logic        stb;
  logic        wr;
  logic        ack;
  logic [7:0]  data_in;

  modport master (
    output addr, data_out, stb, wr,
    input  ack, data_in
  );

  modport slave (
    input  addr, data_out, stb, wr,
    output ack, data_in
  );
endinterface

// File: rtl/xram_arbiter.sv
// Round-robin arbiter sharing the single XRAM port between three masters
// (m0 = 8051 core, m1 = mem_wr copy engine, m2 = spare accelerator).
//
//   state | meaning
//   IDLE  | no grant; xram_* and all acks held at 0; arbitrating pending stb
//   BUSY  | arb_grant owns the XRAM port; counting beats and watchdog cycles
//
// A grant is released when the owner drops stb, when it has used up its beat
// window while someone else waits, or when the watchdog sees no ack for
// TIMEOUT cycles (which also sets the sticky arb_timeout flag).
module xram_arbiter #(
  parameter int unsigned MAX_BEATS = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  xram_arbiter_if.slave         m0,
  xram_arbiter_if.slave         m1,
  xram_arbiter_if.slave         m2,
  xram_arbiter_if.master        xram,
  output logic [1:0]            arb_grant,
  output logic                  arb_busy,
  output logic                  arb_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b11;
  localparam logic [7:0] BEAT_LAST  = 8'(MAX_BEATS - 1);
  localparam logic [7:0] WD_LAST    = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic [7:0]  wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;

  logic [2:0]  stb_v;
  logic [15:0] x_addr;
  logic [7:0]  x_dout;
  logic        x_stb;
  logic        x_wr;
  logic [2:0]  ack_v;
  logic        others_req;
  logic [2:0]  cand;
  logic [1:0]  pick;
  logic        rel_wd;
  logic        rel_beats;
  logic        rel_drop;

  assign stb_v = {m2.stb, m1.stb, m0.stb};

  assign xram.addr     = x_addr;
  assign xram.data_out = x_dout;
  assign xram.stb      = x_stb;
  assign xram.wr       = x_wr;

  assign m0.ack = ack_v[0];
  assign m1.ack = ack_v[1];
  assign m2.ack = ack_v[2];

  // Read data is broadcast; only the acked master consumes it.
  assign m0.data_in = xram.data_in;
  assign m1.data_in = xram.data_in;
  assign m2.data_in = xram.data_in;

  assign arb_grant   = grant_q;
  assign arb_busy    = (state_q == BUSY);
  assign arb_timeout = timeout_q;

  // State, grant, pointer, counters and sticky flag; reset drops any grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= GRANT_NONE;
      rr_ptr_q   <= 2'd0;
      beat_cnt_q <= 8'd0;
      wd_cnt_q   <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Arbitration, port mux, ack routing and release decisions.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    wd_cnt_d   = wd_cnt_q;
    timeout_d  = timeout_q;
    x_addr     = 16'd0;
    x_dout     = 8'd0;
    x_stb      = 1'b0;
    x_wr       = 1'b0;
    ack_v      = 3'b000;
    others_req = 1'b0;
    cand       = 3'd0;
    pick       = GRANT_NONE;
    rel_wd     = 1'b0;
    rel_beats  = 1'b0;
    rel_drop   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Scan from the highest offset down so the first requester after
        // rr_ptr is the last one written and therefore wins.
        for (int i = 2; i >= 0; i--) begin
          cand = {1'b0, rr_ptr_q} + 3'(i);
          if (cand >= 3'd3) cand = cand - 3'd3;
          if (stb_v[cand[1:0]]) pick = cand[1:0];
        end
        if (pick != GRANT_NONE) begin
          grant_d    = pick;
          state_d    = BUSY;
          beat_cnt_d = 8'd0;
          wd_cnt_d   = 8'd0;
        end
      end

      BUSY: begin
        case (grant_q)
          2'd0: begin
            x_addr = m0.addr; x_dout = m0.data_out; x_stb = m0.stb; x_wr = m0.wr;
            ack_v[0]   = xram.ack & m0.stb;
            others_req = m1.stb | m2.stb;
          end
          2'd1: begin
            x_addr = m1.addr; x_dout = m1.data_out; x_stb = m1.stb; x_wr = m1.wr;
            ack_v[1]   = xram.ack & m1.stb;
            others_req = m0.stb | m2.stb;
          end
          2'd2: begin
            x_addr = m2.addr; x_dout = m2.data_out; x_stb = m2.stb; x_wr = m2.wr;
            ack_v[2]   = xram.ack & m2.stb;
            others_req = m0.stb | m1.stb;
          end
          default: ;
        endcase

        // beat_cnt counts within the current beat window and restarts at
        // MAX_BEATS, so a master that streams on after a window with no
        // contender is limited again at the next window boundary.
        if (xram.ack) begin
          beat_cnt_d = (beat_cnt_q == BEAT_LAST) ? 8'd0 : beat_cnt_q + 8'd1;
          wd_cnt_d   = 8'd0;
        end else if (wd_cnt_q != 8'hff) begin
          wd_cnt_d   = wd_cnt_q + 8'd1;
        end

        rel_wd    = !xram.ack && (wd_cnt_q == WD_LAST);
        rel_beats = xram.ack && (beat_cnt_q == BEAT_LAST) && others_req;
        rel_drop  = !x_stb;

        if (rel_wd || rel_beats || rel_drop) begin
          state_d   = IDLE;
          grant_d   = GRANT_NONE;
          rr_ptr_d  = (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
          if (rel_wd) timeout_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = GRANT_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_xram_arbiter.sv
// Bench for xram_arbiter: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level model of the arbiter.
module tb_xram_arbiter;
  localparam int MAXB = 4;
  localparam int TMO  = 16;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  xram_arbiter_if m0_if ();
  xram_arbiter_if m1_if ();
  xram_arbiter_if m2_if ();
  xram_arbiter_if xr_if ();

  logic [1:0] arb_grant;
  logic       arb_busy;
  logic       arb_timeout;

  xram_arbiter #(.MAX_BEATS(MAXB), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .m0          (m0_if.slave),
    .m1          (m1_if.slave),
    .m2          (m2_if.slave),
    .xram        (xr_if.master),
    .arb_grant   (arb_grant),
    .arb_busy    (arb_busy),
    .arb_timeout (arb_timeout)
  );

  // Master-side stimulus
  logic [2:0]  stb;
  logic [15:0] addr [3];
  logic [7:0]  dout [3];
  logic [2:0]  wr;
  logic        ack_x;
  logic [7:0]  din_x;
  int          beats_left [3];   // remaining transfers; -1 = stream forever
  int          ack_mode;         // 0 never, 1 whenever strobed, 2 random
  bit          din_force;
  logic [7:0]  din_val;

  assign m0_if.addr = addr[0]; assign m0_if.data_out = dout[0]; assign m0_if.stb = stb[0]; assign m0_if.wr = wr[0];
  assign m1_if.addr = addr[1]; assign m1_if.data_out = dout[1]; assign m1_if.stb = stb[1]; assign m1_if.wr = wr[1];
  assign m2_if.addr = addr[2]; assign m2_if.data_out = dout[2]; assign m2_if.stb = stb[2]; assign m2_if.wr = wr[2];
  assign xr_if.ack     = ack_x;
  assign xr_if.data_in = din_x;

  // Reference model: who owns the port, whose turn is next, beats served
  // this grant, consecutive cycles without ack, and the sticky timeout.
  int owner;
  int rr;
  int beats;
  int silent;
  bit tmo;

  logic [1:0]  e_grant;
  logic        e_busy;
  logic        e_xstb;
  logic [15:0] e_addr;
  logic [7:0]  e_dout;
  logic        e_wr;
  logic [2:0]  e_ack;

  // Observations of the current cycle
  logic [1:0] o_grant;
  logic       o_busy;
  logic       o_xstb;
  logic [2:0] o_ack;
  logic [7:0] o_din0;
  logic [15:0] o_xaddr;
  logic       o_xwr;

  int tests;
  int failed;
  int cyc;
  int ack_cnt [3];
  int last_ack_cyc [3];
  int grant_log [$];
  int grant_cyc [$];
  logic [1:0] prev_grant;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_txn(input int i);
    addr[i] = 16'($urandom);
    dout[i] = 8'($urandom);
    wr[i]   = 1'($urandom_range(0, 1));
  endtask

  task automatic raise(input int i, input int n);
    beats_left[i] = n;
    new_txn(i);
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 3; i++) begin ack_cnt[i] = 0; last_ack_cyc[i] = -1; end
    grant_log.delete();
    grant_cyc.delete();
  endtask

  task automatic predict();
    e_ack = 3'b000;
    if (owner < 0) begin
      e_grant = 2'b11; e_busy = 1'b0; e_xstb = 1'b0;
      e_addr = 16'd0; e_dout = 8'd0; e_wr = 1'b0;
    end else begin
      e_grant = 2'(owner); e_busy = 1'b1; e_xstb = stb[owner];
      e_addr = addr[owner]; e_dout = dout[owner]; e_wr = wr[owner];
      e_ack[owner] = ack_x & stb[owner];
    end
  endtask

  task automatic model_update();
    bit others, tout, lim, drop;
    if (rst) begin
      owner = -1; rr = 0; beats = 0; silent = 0; tmo = 1'b0;
    end else if (owner < 0) begin
      for (int k = 0; k < 3; k++)
        if (owner < 0 && stb[(rr + k) % 3]) owner = (rr + k) % 3;
      beats = 0; silent = 0;
    end else begin
      others = 1'b0;
      for (int j = 0; j < 3; j++) if (j != owner && stb[j]) others = 1'b1;
      tout = !ack_x && (silent == TMO - 1);
      lim  = ack_x && ((beats + 1) % MAXB == 0) && others;
      drop = !stb[owner];
      if (ack_x) begin beats++; silent = 0; end
      else if (silent < 255) silent++;
      if (tout || lim || drop) begin
        if (tout) tmo = 1'b1;
        rr = (owner + 1) % 3;
        owner = -1;
      end
    end
  endtask

  // One clock cycle: drive at negedge, check just after, advance model at posedge.
  task automatic step();
    cyc++;
    for (int i = 0; i < 3; i++) stb[i] = (beats_left[i] != 0);
    ack_x = 1'b0;
    predict();
    if (!rst) begin
      case (ack_mode)
        1: ack_x = e_xstb;
        2: ack_x = e_xstb && ($urandom_range(0, 9) < 7);
        default: ack_x = 1'b0;
      endcase
    end
    din_x = din_force ? din_val : 8'($urandom);
    predict();
    #1;
    o_grant = arb_grant; o_busy = arb_busy; o_xstb = xr_if.stb;
    o_ack = {m2_if.ack, m1_if.ack, m0_if.ack};
    o_din0 = m0_if.data_in; o_xaddr = xr_if.addr; o_xwr = xr_if.wr;
    check("status", 64'({arb_grant, arb_busy, arb_timeout}), 64'({e_grant, e_busy, tmo}));
    check("xram_bus", 64'({xr_if.addr, xr_if.data_out, xr_if.stb, xr_if.wr}),
          64'({e_addr, e_dout, e_xstb, e_wr}));
    check("acks", 64'(o_ack), 64'(e_ack));
    check("data_in", 64'({m0_if.data_in, m1_if.data_in, m2_if.data_in}), 64'({3{din_x}}));
    if (arb_grant != 2'b11 && prev_grant == 2'b11) begin
      grant_log.push_back(int'(arb_grant));
      grant_cyc.push_back(cyc);
    end
    prev_grant = arb_grant;
    for (int i = 0; i < 3; i++) if (o_ack[i]) begin ack_cnt[i]++; last_ack_cyc[i] = cyc; end
    @(posedge clk);
    model_update();
    for (int i = 0; i < 3; i++) if (e_ack[i]) begin
      if (beats_left[i] > 0) beats_left[i]--;
      new_txn(i);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) beats_left[i] = 0;
    step(); step();
    rst = 1'b0;
  endtask

  function automatic int log_at(input int k);
    return (grant_log.size() > k) ? grant_log[k] : -1;
  endfunction

  function automatic int cyc_at(input int k);
    return (grant_cyc.size() > k) ? grant_cyc[k] : -100;
  endfunction

  int c0;

  initial begin
    tests = 0; failed = 0; cyc = 0;
    rst = 1'b1; ack_mode = 1; din_force = 1'b0; din_val = 8'h00;
    stb = 3'b000; wr = 3'b000; ack_x = 1'b0; din_x = 8'h00;
    for (int i = 0; i < 3; i++) begin addr[i] = 16'd0; dout[i] = 8'd0; beats_left[i] = 0; end
    owner = -1; rr = 0; beats = 0; silent = 0; tmo = 1'b0; prev_grant = 2'b11;
    clear_logs();
    @(negedge clk);

    // Reset state
    do_reset();
    step();
    check("rst_grant", 64'(o_grant), 64'(2'b11));
    check("rst_busy_timeout", 64'({o_busy, arb_timeout}), 64'(2'b00));

    // 1: m1 alone for 10 beats, ack every cycle
    do_reset(); clear_logs(); ack_mode = 1;
    raise(1, 10); c0 = cyc + 1;
    repeat (30) step();
    check("t1_grant", 64'(log_at(0)), 64'(1));
    check("t1_latency", 64'(cyc_at(0) - c0), 64'(1));
    check("t1_grants", 64'(grant_log.size()), 64'(1));
    check("t1_acks", 64'({8'(ack_cnt[0]), 8'(ack_cnt[1]), 8'(ack_cnt[2])}), 64'({8'd0, 8'd10, 8'd0}));

    // 2: all three streaming, 4-beat windows, round robin with 1 idle gap
    do_reset(); clear_logs();
    raise(0, -1); raise(1, -1); raise(2, -1); c0 = cyc + 1;
    repeat (16) step();
    check("t2_acks", 64'({8'(ack_cnt[0]), 8'(ack_cnt[1]), 8'(ack_cnt[2])}), 64'({8'd4, 8'd4, 8'd4}));
    step();
    check("t2_order", 64'({8'(log_at(0)), 8'(log_at(1)), 8'(log_at(2)), 8'(log_at(3))}),
          64'({8'd0, 8'd1, 8'd2, 8'd0}));
    check("t2_first", 64'(cyc_at(0) - c0), 64'(1));
    check("t2_gaps", 64'({8'(cyc_at(1) - cyc_at(0)), 8'(cyc_at(2) - cyc_at(1)), 8'(cyc_at(3) - cyc_at(2))}),
          64'({8'd5, 8'd5, 8'd5}));

    // 3: m1 streaming, m0 joins after beat 6; m1 stops at beat 8
    do_reset(); clear_logs();
    raise(1, -1);
    for (int n = 0; n < 40 && ack_cnt[1] < 6; n++) step();
    raise(0, -1);
    for (int n = 0; n < 20 && grant_log.size() < 2; n++) step();
    check("t3_beats", 64'(ack_cnt[1]), 64'(8));
    check("t3_next", 64'(log_at(1)), 64'(0));
    check("t3_delay", 64'(cyc_at(1) - last_ack_cyc[1]), 64'(2));

    // 4: m2 never acked, watchdog releases after TMO busy cycles
    do_reset(); clear_logs(); ack_mode = 0;
    raise(2, 1);
    step(); step();
    raise(0, 1);
    for (int n = 0; n < 40 && grant_log.size() < 2; n++) step();
    check("t4_order", 64'({8'(log_at(0)), 8'(log_at(1))}), 64'({8'd2, 8'd0}));
    check("t4_busy_len", 64'(cyc_at(1) - cyc_at(0)), 64'(TMO + 1));
    check("t4_flag", 64'(arb_timeout), 64'(1));
    ack_mode = 1;
    repeat (10) step();
    check("t4_sticky", 64'(arb_timeout), 64'(1));
    check("t4_served", 64'({8'(ack_cnt[0]), 8'(ack_cnt[2])}), 64'({8'd1, 8'd1}));

    // 5: reset in the middle of m0's grant
    do_reset(); clear_logs(); ack_mode = 1;
    raise(0, -1);
    repeat (4) step();
    rst = 1'b1; step(); rst = 1'b0;
    step();
    check("t5_after_rst", 64'({o_grant, o_xstb, o_ack[0]}), 64'({2'b11, 1'b0, 1'b0}));
    step();
    check("t5_regrant", 64'(o_grant), 64'(0));

    // 6: single read by m0
    do_reset(); clear_logs(); ack_mode = 1;
    din_force = 1'b1; din_val = 8'h02;
    raise(0, 1); addr[0] = 16'hf9f1; wr[0] = 1'b0;
    step();
    step();
    check("t6_read", 64'({o_din0, o_ack, o_xaddr, o_xwr}), 64'({8'h02, 3'b001, 16'hf9f1, 1'b0}));
    step();
    check("t6_hold", 64'({o_grant, o_busy}), 64'({2'd0, 1'b1}));
    step();
    check("t6_idle", 64'({o_grant, o_busy}), 64'({2'b11, 1'b0}));
    raise(0, 1); raise(1, 1);
    step(); step();
    check("t6_rr", 64'(o_grant), 64'(1));
    din_force = 1'b0;

    // Random traffic with occasional ack droughts to hit the watchdog
    do_reset(); clear_logs();
    for (int n = 0; n < 3000; n++) begin
      ack_mode = ((n % 600) < 30) ? 0 : 2;
      for (int i = 0; i < 3; i++)
        if (beats_left[i] == 0 && $urandom_range(0, 4) == 0) raise(i, $urandom_range(1, 6));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
